cla_seq_arbiter: RTL and testbench

//  Shares one external cla_4bit_add (4-bit carry look-ahead adder) between two requesters.

---
 rtl/cla_seq_arbiter.sv | 151 +++++++++++++++
 tb/tb_cla_seq_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_arbiter.sv
// cla_seq_arbiter: shares one external 4-bit carry look-ahead adder between two
// requesters. Each accepted operation is added nibble-serially, LSB nibble first,
// with the carry between nibbles held in a register. Requests are granted
// round-robin. Results leave on a single valid/ready response channel tagged
// with the owning requester.
module cla_seq_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic              i_req0_cin,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic              i_req1_cin,
  output logic [3:0]        o_cla_a,
  output logic [3:0]        o_cla_b,
  output logic              o_cla_cin,
  input  logic [3:0]        i_cla_s,
  input  logic              i_cla_c,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_sum,
  output logic              o_rsp_cout,
  output logic              o_rsp_id,
  output logic              o_busy
);

  // Number of nibbles per operand and the width of the nibble index.
  localparam int NIB = DATA_W / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] b_reg;
  logic [DATA_W-1:0] sum_reg;
  logic              carry_reg;
  logic              id_reg;
  logic [IDX_W-1:0]  idx;
  // Id of the requester granted most recently; the other one wins a tie.
  logic              last_grant;

  logic              grant;
  logic              can_accept;
  logic [IDX_W+1:0]  bit_base;

  assign bit_base = {idx, 2'b00};

  // Round-robin grant selection and the combinational request-ready outputs.
  always_comb begin
    grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      grant = ~last_grant;
    end else if (i_req1_valid) begin
      grant = 1'b1;
    end
    can_accept   = (state == IDLE) && !i_rst;
    o_req0_ready = can_accept && i_req0_valid && !grant;
    o_req1_ready = can_accept && i_req1_valid && grant;
  end

  // Shared-adder drive and response outputs, all forced to zero outside their phase.
  always_comb begin
    o_cla_a     = 4'd0;
    o_cla_b     = 4'd0;
    o_cla_cin   = 1'b0;
    o_rsp_valid = 1'b0;
    o_rsp_sum   = '0;
    o_rsp_cout  = 1'b0;
    o_rsp_id    = 1'b0;
    o_busy      = (state != IDLE);
    if (state == ADD) begin
      o_cla_a   = a_reg[bit_base +: 4];
      o_cla_b   = b_reg[bit_base +: 4];
      o_cla_cin = carry_reg;
    end
    if (state == RESP) begin
      o_rsp_valid = 1'b1;
      o_rsp_sum   = sum_reg;
      o_rsp_cout  = carry_reg;
      o_rsp_id    = id_reg;
    end
  end

  // Main FSM: accept a request, walk the nibbles through the adder, then hold the result.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_reg    <= '0;
      carry_reg  <= 1'b0;
      id_reg     <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (o_req0_ready) begin
            a_reg     <= i_req0_a;
            b_reg     <= i_req0_b;
            carry_reg <= i_req0_cin;
            id_reg    <= 1'b0;
            sum_reg   <= '0;
            idx       <= '0;
            state     <= ADD;
          end else if (o_req1_ready) begin
            a_reg     <= i_req1_a;
            b_reg     <= i_req1_b;
            carry_reg <= i_req1_cin;
            id_reg    <= 1'b1;
            sum_reg   <= '0;
            idx       <= '0;
            state     <= ADD;
          end
        end
        ADD: begin
          sum_reg[bit_base +: 4] <= i_cla_s;
          carry_reg              <= i_cla_c;
          idx                    <= idx + IDX_ONE;
          if (idx == IDX_LAST) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            last_grant <= id_reg;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_arbiter.sv
// tb_cla_seq_arbiter: directed bench for cla_seq_arbiter with a behavioural
// 4-bit adder on the shared-adder port. Expected responses are queued at each
// request handshake and checked by an independent response monitor.
module tb_cla_seq_arbiter;

  localparam int DATA_W = 16;
  localparam int NIB = DATA_W / 4;

  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              id;
  } rsp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_cin;
  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_cin;
  logic [3:0]        cla_a;
  logic [3:0]        cla_b;
  logic              cla_cin;
  logic [3:0]        cla_s;
  logic              cla_c;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_sum;
  logic              rsp_cout;
  logic              rsp_id;
  logic              busy;

  rsp_t              sb_q[$];
  int                grant_log[$];
  int                grant_cyc[$];
  int                cycle = 0;
  logic [DATA_W-1:0] exp_sum [2];
  logic              exp_cout [2];
  int                tests_run = 0;
  int                fail_count = 0;

  cla_seq_arbiter #(.DATA_W(DATA_W)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_req0_valid(req0_valid),
    .o_req0_ready(req0_ready),
    .i_req0_a(req0_a),
    .i_req0_b(req0_b),
    .i_req0_cin(req0_cin),
    .i_req1_valid(req1_valid),
    .o_req1_ready(req1_ready),
    .i_req1_a(req1_a),
    .i_req1_b(req1_b),
    .i_req1_cin(req1_cin),
    .o_cla_a(cla_a),
    .o_cla_b(cla_b),
    .o_cla_cin(cla_cin),
    .i_cla_s(cla_s),
    .i_cla_c(cla_c),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_sum(rsp_sum),
    .o_rsp_cout(rsp_cout),
    .o_rsp_id(rsp_id),
    .o_busy(busy)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Cycle counter used to time handshakes.
  always @(posedge clk) cycle++;

  // Behavioural shared 4-bit adder.
  assign {cla_c, cla_s} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard producer: on each request handshake queue the hand-computed result.
  always @(negedge clk) begin
    if (!rst && req0_valid && req0_ready) begin
      sb_q.push_back({exp_sum[0], exp_cout[0], 1'b0});
      grant_log.push_back(0);
      grant_cyc.push_back(cycle);
    end
    if (!rst && req1_valid && req1_ready) begin
      sb_q.push_back({exp_sum[1], exp_cout[1], 1'b1});
      grant_log.push_back(1);
      grant_cyc.push_back(cycle);
    end
  end

  // Scoreboard consumer: compare every delivered response with the queue head.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        checkOutput("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        checkOutput("rsp_sum", 32'(rsp_sum), 32'(e.sum));
        checkOutput("rsp_cout", 32'(rsp_cout), 32'(e.cout));
        checkOutput("rsp_id", 32'(rsp_id), 32'(e.id));
      end
    end
  end

  // Raise one request, wait (bounded) for its handshake, then drop valid.
  task automatic applyStimulus(input int id, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                               input logic cin, input logic [DATA_W-1:0] s, input logic c,
                               output int wait_cycles);
    bit got;
    @(posedge clk);
    #1;
    exp_sum[id]  = s;
    exp_cout[id] = c;
    if (id == 0) begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_valid = 1'b1;
    end
    got = 1'b0;
    wait_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        got = 1'b1;
        break;
      end
      wait_cycles++;
    end
    if (!got) checkOutput("grant_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Wait (bounded) until the DUT is idle and every queued response was seen.
  task automatic waitDrain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!busy && sb_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    int w;
    int lat;
    int busy_cnt;
    int seen;
    bit hit;
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_ready0", 32'(req0_ready), 32'd0);
    checkOutput("rst_ready1", 32'(req1_ready), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    checkOutput("rst_rsp_cout", 32'(rsp_cout), 32'd0);
    checkOutput("rst_rsp_id", 32'(rsp_id), 32'd0);
    checkOutput("rst_cla_a", 32'(cla_a), 32'd0);
    checkOutput("rst_cla_b", 32'(cla_b), 32'd0);
    checkOutput("rst_cla_cin", 32'(cla_cin), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);

    $display("[TB] basic add and latency");
    applyStimulus(0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, w);
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) break;
    end
    checkOutput("latency", 32'(lat), 32'(NIB + 1));
    waitDrain("drain_t1");

    $display("[TB] carry out and wrap");
    applyStimulus(0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, w);
    waitDrain("drain_t2a");
    applyStimulus(0, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, w);
    waitDrain("drain_t2b");

    $display("[TB] lone req1 with pointer favouring req1");
    applyStimulus(1, 16'h0001, 16'h0002, 1'b1, 16'h0004, 1'b0, w);
    checkOutput("lone_req1_wait", 32'(w), 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      busy_cnt++;
    end
    checkOutput("busy_cycles", 32'(busy_cnt), 32'(NIB + 1));
    waitDrain("drain_t6");

    $display("[TB] round robin with both requesters");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    grant_log.delete();
    grant_cyc.delete();
    exp_sum[0] = 16'h8000; exp_cout[0] = 1'b0;
    exp_sum[1] = 16'h0001; exp_cout[1] = 1'b1;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_cin = 1'b0;
    req1_a = 16'hF0F0; req1_b = 16'h0F10; req1_cin = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (grant_log.size() >= 4) begin
        hit = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("rr_grant_count", 32'(hit), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) checkOutput($sformatf("rr_grant%0d", i), 32'(grant_log[i]), 32'(i % 2));
    end
    if (grant_cyc.size() >= 2) checkOutput("issue_interval", 32'(grant_cyc[1] - grant_cyc[0]), 32'(NIB + 2));
    waitDrain("drain_t3");

    $display("[TB] response backpressure");
    rsp_ready = 1'b0;
    applyStimulus(0, 16'h00FF, 16'h0F01, 1'b1, 16'h1001, 1'b0, w);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    @(posedge clk); #1;
    exp_sum[1] = 16'hBCDE; exp_cout[1] = 1'b0;
    req1_a = 16'hABCD; req1_b = 16'h1111; req1_cin = 1'b0;
    req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(rsp_valid), 32'd1);
      checkOutput("hold_sum", 32'(rsp_sum), 32'h1001);
      checkOutput("hold_cout", 32'(rsp_cout), 32'd0);
      checkOutput("hold_id", 32'(rsp_id), 32'd0);
      checkOutput("hold_ready0", 32'(req0_ready), 32'd0);
      checkOutput("hold_ready1", 32'(req1_ready), 32'd0);
      checkOutput("hold_cla_a", 32'(cla_a), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req1_ready) begin
        hit = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    checkOutput("req1_after_hold", 32'(hit), 32'd1);
    waitDrain("drain_t4");

    $display("[TB] reset mid-operation");
    applyStimulus(0, 16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    checkOutput("mid_rst_busy", 32'(busy), 32'd0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("mid_rst_cla_a", 32'(cla_a), 32'd0);
    checkOutput("mid_rst_cla_b", 32'(cla_b), 32'd0);
    checkOutput("mid_rst_cla_cin", 32'(cla_cin), 32'd0);
    checkOutput("mid_rst_sum", 32'(rsp_sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    checkOutput("no_rsp_after_rst", 32'(seen), 32'd0);
    applyStimulus(1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, w);
    waitDrain("drain_t5");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
    $finish;
  end

endmodule
